// File: rtl/attn_pkg.sv
// Shared attention-pipeline types: FSM state encoding for the tile statistics
// stage and the pruning-ratio codes consumed by the downstream threshold stage.
package attn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PRUNE_NONE     = 2'd0,
    PRUNE_QUARTER  = 2'd1,
    PRUNE_HALF     = 2'd2,
    PRUNE_3QUARTER = 2'd3
  } prune_ratio_t;

  localparam int unsigned DEFAULT_WIDTH     = 8;
  localparam int unsigned DEFAULT_FRAC_BITS = 8;
  localparam int unsigned DEFAULT_MAX_TILES = 64;

endpackage

// File: rtl/tile_stats_lane.sv
// One lane of running min/max/sum over accepted tile scores.
// With TILE_STATS_SAT_SUM_EN defined the sum saturates and flags each clipping add.
module tile_stats_lane #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         acc,
  input  logic [W-1:0] score,
`ifdef TILE_STATS_SAT_SUM_EN
  output logic         sat_set_c,
`endif
  output logic [W-1:0] min_o,
  output logic [W-1:0] max_o,
  output logic [W-1:0] sum_o
);

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  logic [W-1:0] min_q, min_d;
  logic [W-1:0] max_q, max_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W:0]   sum_ext;

  always_comb begin
    min_d   = min_q;
    max_d   = max_q;
    sum_d   = sum_q;
    sum_ext = {1'b0, sum_q} + {1'b0, score};
`ifdef TILE_STATS_SAT_SUM_EN
    sat_set_c = 1'b0;
`endif
    if (clr) begin
      min_d = ALL_ONES;
      max_d = '0;
      sum_d = '0;
    end else if (acc) begin
      min_d = (score < min_q) ? score : min_q;
      max_d = (score > max_q) ? score : max_q;
`ifdef TILE_STATS_SAT_SUM_EN
      // Carry out of the extended add means the true sum no longer fits.
      if (sum_ext[W]) begin
        sum_d     = ALL_ONES;
        sat_set_c = 1'b1;
      end else begin
        sum_d = sum_ext[W-1:0];
      end
`else
      sum_d = sum_ext[W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= ALL_ONES;
      max_q <= '0;
      sum_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
      sum_q <= sum_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;
  assign sum_o = sum_q;

endmodule

// File: rtl/tile_stats_accumulator.sv
// Per-block tile statistics (min/max/sum per head, tile count) held for the threshold stage.
// Optional macro TILE_STATS_SAT_SUM_EN: saturating sums plus the sum_sat flag.
module tile_stats_accumulator
  import attn_pkg::*;
#(
  parameter int unsigned width           = DEFAULT_WIDTH,
  parameter int unsigned FRACTIONAL_BITS = DEFAULT_FRAC_BITS,
  parameter int unsigned MAX_TILES       = DEFAULT_MAX_TILES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 tile_valid,
  output logic                 tile_ready,
  input  logic                 tile_last,
  input  logic [2*width-1:0]   score0,
  input  logic [2*width-1:0]   score1,
  output logic [2*width-1:0]   min0,
  output logic [2*width-1:0]   max0,
  output logic [2*width-1:0]   sum0,
  output logic [2*width-1:0]   min1,
  output logic [2*width-1:0]   max1,
  output logic [2*width-1:0]   sum1,
  output logic [2*width-1:0]   no_of_tiles,
  output logic                 stats_valid,
  input  logic                 stats_ack,
  output logic                 len_err,
`ifdef TILE_STATS_SAT_SUM_EN
  output logic                 sum_sat,
`endif
  output logic                 busy
);

  localparam int unsigned     BW       = 2 * width;
  localparam logic [BW-1:0]   CAP_LAST = BW'(MAX_TILES - 1);

  if (MAX_TILES < 1 || 64'(MAX_TILES) >= (64'(1) << BW)) begin : gen_bad_max_tiles
    $error("MAX_TILES out of range for the count width");
  end
  if (FRACTIONAL_BITS > BW) begin : gen_bad_frac_bits
    $error("FRACTIONAL_BITS exceeds the score width");
  end

  state_t        state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          len_err_q, len_err_d;
  logic          tile_ready_q, tile_ready_d;
  logic          stats_valid_q, stats_valid_d;
  logic          busy_q, busy_d;
  logic          clr, acc;

  // Next-state, count and strobes; status flops track the next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_err_d = len_err_q;
    clr       = 1'b0;
    acc       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ACCUM;
          cnt_d     = '0;
          len_err_d = 1'b0;
          clr       = 1'b1;
        end
      end
      ACCUM: begin
        if (tile_valid && tile_ready_q) begin
          acc   = 1'b1;
          cnt_d = cnt_q + BW'(1);
          if (tile_last) begin
            state_d = DONE;
          end else if (cnt_q == CAP_LAST) begin
            state_d   = DONE;
            len_err_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (stats_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tile_ready_d  = (state_d == ACCUM);
    stats_valid_d = (state_d == DONE);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      len_err_q     <= 1'b0;
      tile_ready_q  <= 1'b0;
      stats_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      len_err_q     <= len_err_d;
      tile_ready_q  <= tile_ready_d;
      stats_valid_q <= stats_valid_d;
      busy_q        <= busy_d;
    end
  end

`ifdef TILE_STATS_SAT_SUM_EN
  logic sat0_c, sat1_c;
  logic sum_sat_q, sum_sat_d;

  always_comb begin
    sum_sat_d = sum_sat_q;
    if (clr) sum_sat_d = 1'b0;
    else if (sat0_c || sat1_c) sum_sat_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_sat_q <= 1'b0;
    else     sum_sat_q <= sum_sat_d;
  end

  assign sum_sat = sum_sat_q;
`endif

  tile_stats_lane #(.W(BW)) u_lane0 (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .acc       (acc),
    .score     (score0),
`ifdef TILE_STATS_SAT_SUM_EN
    .sat_set_c (sat0_c),
`endif
    .min_o     (min0),
    .max_o     (max0),
    .sum_o     (sum0)
  );

  tile_stats_lane #(.W(BW)) u_lane1 (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .acc       (acc),
    .score     (score1),
`ifdef TILE_STATS_SAT_SUM_EN
    .sat_set_c (sat1_c),
`endif
    .min_o     (min1),
    .max_o     (max1),
    .sum_o     (sum1)
  );

  assign tile_ready  = tile_ready_q;
  assign stats_valid = stats_valid_q;
  assign no_of_tiles = cnt_q;
  assign len_err     = len_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_tile_stats_accumulator.sv
// Directed self-checking bench: a default instance (MAX_TILES=64) and a capped one (MAX_TILES=4).
module tb_tile_stats_accumulator;

  logic        clk, rst;
  logic        start, tile_valid, tile_last, stats_ack;
  logic [15:0] score0, score1;
  logic        tile_ready, stats_valid, len_err, busy;
  logic [15:0] min0, max0, sum0, min1, max1, sum1, no_of_tiles;

  logic        c_start, c_valid, c_last, c_ack;
  logic [15:0] c_s0, c_s1;
  logic        c_ready, c_valid_o, c_len_err, c_busy;
  logic [15:0] c_min0, c_max0, c_sum0, c_min1, c_max1, c_sum1, c_cnt;
`ifdef TILE_STATS_SAT_SUM_EN
  logic        sum_sat, c_sum_sat;
`endif

  int checks = 0;
  int errors = 0;

  tile_stats_accumulator #(.width(8), .FRACTIONAL_BITS(8), .MAX_TILES(64)) dut (
    .clk(clk), .rst(rst), .start(start), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_last(tile_last), .score0(score0), .score1(score1),
    .min0(min0), .max0(max0), .sum0(sum0), .min1(min1), .max1(max1), .sum1(sum1),
    .no_of_tiles(no_of_tiles), .stats_valid(stats_valid), .stats_ack(stats_ack),
    .len_err(len_err),
`ifdef TILE_STATS_SAT_SUM_EN
    .sum_sat(sum_sat),
`endif
    .busy(busy)
  );

  tile_stats_accumulator #(.width(8), .FRACTIONAL_BITS(8), .MAX_TILES(4)) dut_cap (
    .clk(clk), .rst(rst), .start(c_start), .tile_valid(c_valid), .tile_ready(c_ready),
    .tile_last(c_last), .score0(c_s0), .score1(c_s1),
    .min0(c_min0), .max0(c_max0), .sum0(c_sum0), .min1(c_min1), .max1(c_max1), .sum1(c_sum1),
    .no_of_tiles(c_cnt), .stats_valid(c_valid_o), .stats_ack(c_ack),
    .len_err(c_len_err),
`ifdef TILE_STATS_SAT_SUM_EN
    .sum_sat(c_sum_sat),
`endif
    .busy(c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_ack;
    stats_ack = 1'b1;
    @(posedge clk); #1;
    stats_ack = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] s0, input logic [15:0] s1, input logic last);
    tile_valid = 1'b1; score0 = s0; score1 = s1; tile_last = last;
    @(posedge clk); #1;
    tile_valid = 1'b0; tile_last = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 0; tile_valid = 0; tile_last = 0; stats_ack = 0; score0 = 0; score1 = 0;
    c_start = 0; c_valid = 0; c_last = 0; c_ack = 0; c_s0 = 0; c_s1 = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (min0 !== 16'hFFFF || min1 !== 16'hFFFF) begin errors++; $display("FAIL reset_min got=%h/%h exp=ffff/ffff", min0, min1); end
    checks++; if (max0 !== 16'h0 || max1 !== 16'h0 || sum0 !== 16'h0 || sum1 !== 16'h0) begin errors++; $display("FAIL reset_maxsum got=%h %h %h %h exp=0", max0, max1, sum0, sum1); end
    checks++; if (no_of_tiles !== 16'h0 || stats_valid !== 1'b0 || len_err !== 1'b0 || tile_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_ctrl got cnt=%h sv=%b le=%b tr=%b busy=%b exp all 0", no_of_tiles, stats_valid, len_err, tile_ready, busy); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_block;
    do_start();
    checks++; if (tile_ready !== 1'b1 || busy !== 1'b1 || no_of_tiles !== 16'h0) begin errors++; $display("FAIL t1_open got tr=%b busy=%b cnt=%h exp 1 1 0", tile_ready, busy, no_of_tiles); end
    send_beat(16'd3, 16'd10, 1'b0);
    send_beat(16'd7, 16'd10, 1'b0);
    send_beat(16'd1, 16'd10, 1'b0);
    checks++; if (stats_valid !== 1'b0 || no_of_tiles !== 16'd3) begin errors++; $display("FAIL t1_mid got sv=%b cnt=%0d exp 0 3", stats_valid, no_of_tiles); end
    send_beat(16'd5, 16'd10, 1'b1);
    checks++; if (stats_valid !== 1'b1 || tile_ready !== 1'b0 || len_err !== 1'b0) begin errors++; $display("FAIL t1_done got sv=%b tr=%b le=%b exp 1 0 0", stats_valid, tile_ready, len_err); end
    checks++; if (min0 !== 16'd1 || max0 !== 16'd7 || sum0 !== 16'd16) begin errors++; $display("FAIL t1_lane0 got %0d/%0d/%0d exp 1/7/16", min0, max0, sum0); end
    checks++; if (min1 !== 16'd10 || max1 !== 16'd10 || sum1 !== 16'd40 || no_of_tiles !== 16'd4) begin errors++; $display("FAIL t1_lane1 got %0d/%0d/%0d cnt=%0d exp 10/10/40 4", min1, max1, sum1, no_of_tiles); end
    do_ack();
    checks++; if (stats_valid !== 1'b0 || busy !== 1'b0 || sum0 !== 16'd16) begin errors++; $display("FAIL t1_ack got sv=%b busy=%b sum0=%0d exp 0 0 16", stats_valid, busy, sum0); end
  endtask

  task automatic test_single_tile;
    do_start();
    send_beat(16'h00FF, 16'h0, 1'b1);
    checks++; if (min0 !== 16'h00FF || max0 !== 16'h00FF || sum0 !== 16'h00FF) begin errors++; $display("FAIL t2_lane0 got %h/%h/%h exp 00ff", min0, max0, sum0); end
    checks++; if (min1 !== 16'h0 || max1 !== 16'h0 || sum1 !== 16'h0 || no_of_tiles !== 16'd1 || stats_valid !== 1'b1) begin errors++; $display("FAIL t2_lane1 got %h/%h/%h cnt=%0d sv=%b exp 0/0/0 1 1", min1, max1, sum1, no_of_tiles, stats_valid); end
    do_ack();
  endtask

  task automatic test_backpressure;
    int  idx;
    int  cyc;
    logic v, hs;
    idx = 0; cyc = 0;
    do_start();
    while (idx < 10 && cyc < 300) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        tile_valid = 1'b1; score0 = 16'(idx + 1); score1 = 16'(50 - idx); tile_last = (idx == 9);
      end else begin
        tile_valid = 1'b0; score0 = 16'h0; score1 = 16'hFFFF; tile_last = 1'b1;
      end
      hs = v && tile_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) idx++;
    end
    tile_valid = 1'b0; tile_last = 1'b0;
    checks++; if (idx != 10) begin errors++; $display("FAIL t3_timeout accepted=%0d exp 10", idx); end
    checks++; if (no_of_tiles !== 16'd10 || stats_valid !== 1'b1) begin errors++; $display("FAIL t3_count got cnt=%0d sv=%b exp 10 1", no_of_tiles, stats_valid); end
    checks++; if (min0 !== 16'd1 || max0 !== 16'd10 || sum0 !== 16'd55) begin errors++; $display("FAIL t3_lane0 got %0d/%0d/%0d exp 1/10/55", min0, max0, sum0); end
    checks++; if (min1 !== 16'd41 || max1 !== 16'd50 || sum1 !== 16'd455) begin errors++; $display("FAIL t3_lane1 got %0d/%0d/%0d exp 41/50/455", min1, max1, sum1); end
    tile_valid = 1'b1; score0 = 16'h0; score1 = 16'hFFFF; tile_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (stats_valid !== 1'b1 || tile_ready !== 1'b0 || no_of_tiles !== 16'd10 || min0 !== 16'd1 || max1 !== 16'd50) begin errors++; $display("FAIL t3_hold cyc=%0d got sv=%b tr=%b cnt=%0d min0=%0d max1=%0d", i, stats_valid, tile_ready, no_of_tiles, min0, max1); end
    end
    tile_valid = 1'b0; tile_last = 1'b0;
    do_ack();
    checks++; if (stats_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t3_ack got sv=%b busy=%b exp 0 0", stats_valid, busy); end
  endtask

  task automatic test_cap;
    c_start = 1'b1; @(posedge clk); #1; c_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      c_valid = 1'b1; c_last = 1'b0; c_s0 = 16'd5; c_s1 = 16'(i);
      @(posedge clk); #1;
      if (i < 3) begin
        checks++; if (c_valid_o !== 1'b0 || c_cnt !== 16'(i + 1) || c_ready !== 1'b1) begin errors++; $display("FAIL t4_pre beat=%0d got sv=%b cnt=%0d tr=%b", i, c_valid_o, c_cnt, c_ready); end
      end else begin
        checks++; if (c_valid_o !== 1'b1 || c_len_err !== 1'b1 || c_ready !== 1'b0 || c_cnt !== 16'd4) begin errors++; $display("FAIL t4_cap beat=%0d got sv=%b le=%b tr=%b cnt=%0d exp 1 1 0 4", i, c_valid_o, c_len_err, c_ready, c_cnt); end
      end
    end
    c_valid = 1'b0;
    checks++; if (c_sum0 !== 16'd20 || c_max1 !== 16'd3 || c_min1 !== 16'd0) begin errors++; $display("FAIL t4_stats got sum0=%0d max1=%0d min1=%0d exp 20 3 0", c_sum0, c_max1, c_min1); end
    c_ack = 1'b1; @(posedge clk); #1; c_ack = 1'b0;
    c_start = 1'b1; @(posedge clk); #1; c_start = 1'b0;
    checks++; if (c_len_err !== 1'b0 || c_cnt !== 16'd0) begin errors++; $display("FAIL t4_clear got le=%b cnt=%0d exp 0 0", c_len_err, c_cnt); end
    for (int i = 0; i < 4; i++) begin
      c_valid = 1'b1; c_last = (i == 3); c_s0 = 16'd2; c_s1 = 16'd2;
      @(posedge clk); #1;
    end
    c_valid = 1'b0; c_last = 1'b0;
    checks++; if (c_valid_o !== 1'b1 || c_len_err !== 1'b0 || c_cnt !== 16'd4) begin errors++; $display("FAIL t4_last_on_cap got sv=%b le=%b cnt=%0d exp 1 0 4", c_valid_o, c_len_err, c_cnt); end
    c_ack = 1'b1; @(posedge clk); #1; c_ack = 1'b0;
  endtask

  task automatic test_overflow;
    do_start();
    send_beat(16'hFFFF, 16'd1, 1'b0);
    send_beat(16'hFFFF, 16'd1, 1'b1);
`ifdef TILE_STATS_SAT_SUM_EN
    checks++; if (sum0 !== 16'hFFFF || sum_sat !== 1'b1) begin errors++; $display("FAIL t5_sat got sum0=%h sat=%b exp ffff 1", sum0, sum_sat); end
`else
    checks++; if (sum0 !== 16'hFFFE) begin errors++; $display("FAIL t5_wrap got sum0=%h exp fffe", sum0); end
`endif
    checks++; if (max0 !== 16'hFFFF || sum1 !== 16'd2 || no_of_tiles !== 16'd2) begin errors++; $display("FAIL t5_other got max0=%h sum1=%0d cnt=%0d exp ffff 2 2", max0, sum1, no_of_tiles); end
    do_ack();
    do_start();
`ifdef TILE_STATS_SAT_SUM_EN
    checks++; if (sum_sat !== 1'b0) begin errors++; $display("FAIL t5_sat_clear got %b exp 0", sum_sat); end
`endif
    checks++; if (sum0 !== 16'h0 || min0 !== 16'hFFFF) begin errors++; $display("FAIL t5_clear got sum0=%h min0=%h exp 0 ffff", sum0, min0); end
    send_beat(16'd0, 16'd0, 1'b1);
    do_ack();
  endtask

  task automatic test_reset_corners;
    do_start();
    send_beat(16'd4, 16'd4, 1'b0);
    send_beat(16'd2, 16'd2, 1'b0);
    rst = 1'b1; #1;
    checks++; if (busy !== 1'b0 || stats_valid !== 1'b0 || tile_ready !== 1'b0 || no_of_tiles !== 16'd0) begin errors++; $display("FAIL t6_abort got busy=%b sv=%b tr=%b cnt=%0d exp 0 0 0 0", busy, stats_valid, tile_ready, no_of_tiles); end
    checks++; if (min0 !== 16'hFFFF || sum0 !== 16'h0 || max1 !== 16'h0) begin errors++; $display("FAIL t6_abort_stats got min0=%h sum0=%h max1=%h", min0, sum0, max1); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_start();
    send_beat(16'd9, 16'd8, 1'b1);
    checks++; if (min0 !== 16'd9 || sum0 !== 16'd9 || min1 !== 16'd8 || no_of_tiles !== 16'd1 || stats_valid !== 1'b1) begin errors++; $display("FAIL t6_fresh got min0=%0d sum0=%0d min1=%0d cnt=%0d sv=%b", min0, sum0, min1, no_of_tiles, stats_valid); end
    start = 1'b1; stats_ack = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stats_ack = 1'b0;
    checks++; if (busy !== 1'b0 || stats_valid !== 1'b0 || tile_ready !== 1'b0) begin errors++; $display("FAIL t6_ack_wins got busy=%b sv=%b tr=%b exp 0 0 0", busy, stats_valid, tile_ready); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || min0 !== 16'd9 || no_of_tiles !== 16'd1) begin errors++; $display("FAIL t6_no_block got busy=%b min0=%0d cnt=%0d exp 0 9 1", busy, min0, no_of_tiles); end
  endtask

  initial begin
    test_reset();
    test_basic_block();
    test_single_tile();
    test_backpressure();
    test_cap();
    test_overflow();
    test_reset_corners();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_stats_accumulator.md
Name: tile_stats_accumulator

Overview:
- Upstream neighbour of the block-threshold stage: streams per-tile attention scores for two heads (lane 0, lane 1) of one block and accumulates min, max, sum and tile count.
- Presents results as a held, validated bundle (min0/max0/sum0, min1/max1/sum1, no_of_tiles) plus `enable` for the threshold calculator.
- Holds the results until consumed, then returns to idle for the next block.

Parameters:
- width, 8, base word width; all score, stat and count buses are 2*width bits.
- FRACTIONAL_BITS, 8, fixed-point fraction bits of the scores. Used only for documentation and consistency; the arithmetic is format-agnostic.
- MAX_TILES, 64, hard cap on tiles per block (1..2^(2*width)-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that opens a new block; honoured only in IDLE.
- tile_valid  in  1  tile score beat valid.
- tile_ready  out  1  accumulator accepts a beat. Equals (state==ACCUM).
- tile_last  in  1  marks the final tile of the block; qualified by the handshake.
- score0  in  2*width  unsigned tile score, lane 0.
- score1  in  2*width  unsigned tile score, lane 1.
- min0, max0, sum0  out  2*width each  lane 0 statistics.
- min1, max1, sum1  out  2*width each  lane 1 statistics.
- no_of_tiles  out  2*width  count of accepted tiles.
- stats_valid  out  1  statistics stable and valid; drives the threshold calculator `enable`.
- stats_ack  in  1  consumer has taken the statistics.
- len_err  out  1  block was closed by the MAX_TILES cap, not by tile_last.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, ACCUM, DONE. Encoding is two bits.
- Reset (async, any state): state=IDLE.
  - min0=min1 = all ones; max0=max1=sum0=sum1=0; no_of_tiles=0.
  - stats_valid=0, len_err=0, tile_ready=0.
- IDLE -> ACCUM on start.
  - Same edge: min regs = all ones, max/sum/count = 0, len_err = 0.
- ACCUM: a beat is accepted when tile_valid && tile_ready. For each accepted beat, per lane:
  - min <= (score < min) ? score : min.
  - max <= (score > max) ? score : max.
  - sum <= sum + score.
  - no_of_tiles <= no_of_tiles + 1.
- ACCUM -> DONE on the accepted beat with tile_last=1. That beat is included in the statistics.
- ACCUM -> DONE also on the accepted beat that makes no_of_tiles==MAX_TILES while tile_last=0. In that case len_err=1.
  - tile_last on the capping beat counts as a normal close (len_err=0).
- DONE:
  - stats_valid=1; all stat outputs are held constant; tile_ready=0.
  - On stats_ack: next cycle state=IDLE, stats_valid=0. Outputs keep their values until the next start.
- Latency: stats_valid rises on the cycle after the last accepted beat.
- Minimum block is one tile. In that case min=max=sum=score and no_of_tiles=1.
- Ignored inputs:
  - start outside IDLE.
  - stats_ack outside DONE.
  - tile_valid outside ACCUM (no side effects).
- start and stats_ack in the same cycle while in DONE: ack wins, return to IDLE. The start is dropped.
- Sum width is 2*width, unsigned. With the macro absent, overflow wraps modulo 2^(2*width).
- Reset asserted mid-block aborts the block. No partial result is ever flagged valid.

Optional Feature:
- Macro TILE_STATS_SAT_SUM_EN.
- Defined:
  - sum0/sum1 saturate at 2^(2*width)-1 instead of wrapping.
  - Extra output sum_sat (1 bit) is set if either lane saturated in the current block. It is cleared at start and at reset.
- Undefined: wrapping add; the sum_sat port does not exist.

Decomposition:
- Shared package (attn_pkg): state enumeration (IDLE/ACCUM/DONE) and the pruning-ratio codes already used downstream.
- Width-derived constants: all-ones min init and the MAX_TILES check.
- One sub-module, tile_stats_lane: holds min/max/sum for one lane, with clear and accumulate strobes. It is instantiated twice (lane 0, lane 1), and the optional saturation lives inside it.
- FSM and counter stay in the top.

Test Plan:
1. Reset, start, 4 beats:
   - Stimulus: score0=3,7,1,5 and score1=10,10,10,10, last on beat 4.
   - Response: min0=1, max0=7, sum0=16, min1=max1=10, sum1=40, no_of_tiles=4, stats_valid one cycle after beat 4, len_err=0.
2. Single tile:
   - Stimulus: score0=0x00FF, score1=0, tile_last=1.
   - Response: min0=max0=sum0=0x00FF, min1=max1=sum1=0, no_of_tiles=1.
3. Backpressure and idle-time inputs:
   - Stimulus: tile_valid toggled randomly over 10 tiles; stats_ack withheld 5 cycles.
   - Response: only handshaked beats counted (no_of_tiles=10); outputs and stats_valid held until ack; tile_valid in DONE has no effect.
4. Cap, with MAX_TILES=4:
   - Stimulus: 6 beats, no tile_last.
   - Response: DONE after beat 4, len_err=1, tile_ready=0 from then on, no_of_tiles=4.
5. Overflow:
   - Stimulus: two beats of 0xFFFF on lane 0.
   - Response without the macro: sum0=0xFFFE. Response with TILE_STATS_SAT_SUM_EN: sum0=0xFFFF, sum_sat=1.
6. Reset and start/ack corner cases:
   - Stimulus: assert rst after 2 beats.
   - Response: immediate IDLE, reset values, stats_valid=0; a following start/block computes fresh stats. start+stats_ack together in DONE returns to IDLE with no new block opened.
